// File: rtl/reg_file_sb.sv
// reg_file_sb: register file with a per-register scoreboard (busy bits).
// Ports:
//   clock, reset            - single clock, async active-high reset
//   RegWrite/WriteReg/Data  - write port, committed at the rising edge
//   ReadReg1/2, ReadData1/2 - combinational read ports (optional bypass)
//   Reserve/ReserveReg      - mark a register as pending a future write
//   Busy1/2                 - pending-write status of the read registers
//   BusyCount               - registered count of reserved registers
module reg_file_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic [ADDR_W-1:0] ReadReg1,
    input  logic [ADDR_W-1:0] ReadReg2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic              Reserve,
    input  logic [ADDR_W-1:0] ReserveReg,
    output logic              Busy1,
    output logic              Busy2,
    output logic [ADDR_W:0]   BusyCount
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CNT_W = ADDR_W + 1;
    localparam bit HAS_ZERO = (ZERO_REG != 0);
    localparam bit USE_BYP  = (BYPASS != 0);
    localparam logic [CNT_W-1:0] MAX_CNT =
        CNT_W'(HAS_ZERO ? DEPTH - 1 : DEPTH);

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DEPTH-1:0]  busyNext;
    logic [CNT_W-1:0]  busyCnt;
    logic              writeEn;
    logic              reserveEn;
    logic              cntInc;
    logic              cntDec;

    // Inputs are gated by reset so nothing is forwarded or
    // committed while the file is being cleared.
    always_comb begin
        writeEn   = RegWrite && !reset &&
                    !(HAS_ZERO && WriteReg == '0);
        reserveEn = Reserve && !reset &&
                    !(HAS_ZERO && ReserveReg == '0);
    end

    // Clear first, then set: a same-cycle reserve of the written
    // register is a new reservation and must survive.
    always_comb begin
        busyNext = busy;
        if (writeEn)
            busyNext[WriteReg] = 1'b0;
        if (reserveEn)
            busyNext[ReserveReg] = 1'b1;
    end

    // A write only frees a slot when its bit really ends up clear.
    always_comb begin
        cntInc = reserveEn && !busy[ReserveReg];
        cntDec = writeEn && busy[WriteReg] &&
                 !(reserveEn && ReserveReg == WriteReg);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                regs[i] <= '0;
            busy    <= '0;
            busyCnt <= '0;
        end else begin
            if (writeEn)
                regs[WriteReg] <= WriteData;
            busy <= busyNext;
            if (cntInc && !cntDec && busyCnt != MAX_CNT)
                busyCnt <= busyCnt + 1'b1;
            else if (cntDec && !cntInc && busyCnt != '0)
                busyCnt <= busyCnt - 1'b1;
        end
    end

    assign BusyCount = busyCnt;

    always_comb begin
        ReadData1 = regs[ReadReg1];
        Busy1     = busy[ReadReg1];
        if (USE_BYP && writeEn && WriteReg == ReadReg1) begin
            ReadData1 = WriteData;
            Busy1     = 1'b0;
        end
        if (HAS_ZERO && ReadReg1 == '0) begin
            ReadData1 = '0;
            Busy1     = 1'b0;
        end
    end

    always_comb begin
        ReadData2 = regs[ReadReg2];
        Busy2     = busy[ReadReg2];
        if (USE_BYP && writeEn && WriteReg == ReadReg2) begin
            ReadData2 = WriteData;
            Busy2     = 1'b0;
        end
        if (HAS_ZERO && ReadReg2 == '0) begin
            ReadData2 = '0;
            Busy2     = 1'b0;
        end
    end

endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: scoreboard bench for reg_file_sb.
// Two instances share inputs: bypass on (main) and bypass off.
module tb_reg_file_sb;

    logic        clock = 1'b0;
    logic        reset;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [31:0] WriteData;
    logic [4:0]  ReadReg1;
    logic [4:0]  ReadReg2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic        Reserve;
    logic [4:0]  ReserveReg;
    logic        Busy1;
    logic        Busy2;
    logic [5:0]  BusyCount;

    logic [31:0] nbData1;
    logic [31:0] nbData2;
    logic        nbBusy1;
    logic        nbBusy2;
    logic [5:0]  nbCount;

    reg_file_sb dut (
        .clock(clock), .reset(reset),
        .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .Reserve(Reserve), .ReserveReg(ReserveReg),
        .Busy1(Busy1), .Busy2(Busy2),
        .BusyCount(BusyCount)
    );

    reg_file_sb #(.BYPASS(0)) dutNb (
        .clock(clock), .reset(reset),
        .RegWrite(RegWrite), .WriteReg(WriteReg),
        .WriteData(WriteData),
        .ReadReg1(ReadReg1), .ReadReg2(ReadReg2),
        .ReadData1(nbData1), .ReadData2(nbData2),
        .Reserve(Reserve), .ReserveReg(ReserveReg),
        .Busy1(nbBusy1), .Busy2(nbBusy2),
        .BusyCount(nbCount)
    );

    always #5 clock = ~clock;

    typedef struct {
        string       nm;
        logic [31:0] d1;
        logic [31:0] d2;
        logic        b1;
        logic        b2;
        logic [5:0]  cnt;
        logic [31:0] d1nb;
    } exp_t;

    exp_t q[$];
    int   nTests = 0;
    int   nFail  = 0;

    // Monitor: outputs are stable mid-cycle; compare everything queued.
    always @(negedge clock) begin
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            nTests++;
            if (ReadData1 !== e.d1 || ReadData2 !== e.d2 ||
                Busy1 !== e.b1 || Busy2 !== e.b2 ||
                BusyCount !== e.cnt || nbData1 !== e.d1nb) begin
                nFail++;
                $display("FAIL %s: got d1=%h d2=%h b1=%b b2=%b cnt=%0d nb1=%h want d1=%h d2=%h b1=%b b2=%b cnt=%0d nb1=%h",
                         e.nm, ReadData1, ReadData2, Busy1, Busy2,
                         BusyCount, nbData1, e.d1, e.d2, e.b1, e.b2,
                         e.cnt, e.d1nb);
            end
        end
    end

    // Drive one cycle of inputs, queue the expected outputs for
    // this cycle, then advance to just after the next edge.
    task automatic cyc(
        input string       nm,
        input logic        we,
        input logic [4:0]  wa,
        input logic [31:0] wd,
        input logic        rsv,
        input logic [4:0]  ra,
        input logic [4:0]  r1,
        input logic [4:0]  r2,
        input logic [31:0] e1,
        input logic [31:0] e2,
        input logic        eb1,
        input logic        eb2,
        input logic [5:0]  ecnt,
        input logic [31:0] e1nb
    );
        exp_t e;
        RegWrite   = we;
        WriteReg   = wa;
        WriteData  = wd;
        Reserve    = rsv;
        ReserveReg = ra;
        ReadReg1   = r1;
        ReadReg2   = r2;
        e.nm = nm; e.d1 = e1; e.d2 = e2;
        e.b1 = eb1; e.b2 = eb2; e.cnt = ecnt; e.d1nb = e1nb;
        q.push_back(e);
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        RegWrite = 0; WriteReg = 0; WriteData = 0;
        Reserve = 0; ReserveReg = 0; ReadReg1 = 0; ReadReg2 = 0;
        @(posedge clock);
        #1;
        //  name          we wa  wd            rsv ra r1 r2  d1  d2 b1 b2 cnt nb1
        cyc("reset",      1, 1, 32'd9,        1, 3, 1, 2,  0,  0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("wr1_byp",    1, 1, 32'd12,       0, 0, 1, 2, 12,  0, 0, 0, 0, 0);
        cyc("wr2_byp",    1, 2, 32'd8,        0, 0, 1, 2, 12,  8, 0, 0, 0, 12);
        cyc("rd_12_8",    0, 0, 0,            0, 0, 1, 2, 12,  8, 0, 0, 0, 12);
        cyc("zero_wr",    1, 0, 32'hDEADBEEF, 1, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        cyc("zero_after", 0, 0, 0,            0, 0, 0, 0,  0,  0, 0, 0, 0, 0);
        cyc("byp3",       1, 3, 32'd20,       0, 0, 3, 3, 20, 20, 0, 0, 0, 0);
        cyc("rd3",        0, 0, 0,            0, 0, 3, 3, 20, 20, 0, 0, 0, 20);
        cyc("rsv5",       0, 0, 0,            1, 5, 5, 6,  0,  0, 0, 0, 0, 0);
        cyc("rsv6",       0, 0, 0,            1, 6, 5, 6,  0,  0, 1, 0, 1, 0);
        cyc("wr5_busy",   1, 5, 32'd55,       0, 0, 5, 6, 55,  0, 0, 1, 2, 0);
        cyc("after_wr5",  0, 0, 0,            0, 0, 5, 6, 55,  0, 0, 1, 1, 55);
        cyc("rsv7",       0, 0, 0,            1, 7, 7, 6,  0,  0, 0, 1, 1, 0);
        cyc("rsv_wr7",    1, 7, 32'd77,       1, 7, 7, 6, 77,  0, 0, 1, 2, 0);
        cyc("after_7",    0, 0, 0,            0, 0, 7, 6, 77,  0, 1, 1, 2, 77);
        cyc("rsv7_again", 0, 0, 0,            1, 7, 7, 6, 77,  0, 1, 1, 2, 77);
        cyc("cnt_hold",   0, 0, 0,            0, 0, 7, 6, 77,  0, 1, 1, 2, 77);
        cyc("wr6_rsv8",   1, 6, 32'd66,       1, 8, 6, 8, 66,  0, 0, 0, 2, 0);
        cyc("after_6_8",  0, 0, 0,            0, 0, 6, 8, 66,  0, 0, 1, 2, 66);
        cyc("rsv1",       0, 0, 0,            1, 1, 1, 7, 12, 77, 0, 1, 2, 12);
        cyc("rsv2",       0, 0, 0,            1, 2, 1, 7, 12, 77, 1, 1, 3, 12);
        cyc("rsv3",       0, 0, 0,            1, 3, 1, 7, 12, 77, 1, 1, 4, 12);
        cyc("rsv4",       0, 0, 0,            1, 4, 1, 7, 12, 77, 1, 1, 5, 12);
        cyc("pre_rst",    0, 0, 0,            0, 0, 1, 7, 12, 77, 1, 1, 6, 12);
        reset = 1'b1;
        cyc("rst_mid",    0, 0, 0,            0, 0, 1, 7,  0,  0, 0, 0, 0, 0);
        cyc("rst_wr",     1, 1, 32'd99,       1, 2, 1, 2,  0,  0, 0, 0, 0, 0);
        reset = 1'b0;
        cyc("post_rst",   0, 0, 0,            0, 0, 1, 2,  0,  0, 0, 0, 0, 0);
        cyc("wr_resume",  1, 1, 32'd5,        0, 0, 1, 2,  5,  0, 0, 0, 0, 0);
        cyc("rd_resume",  0, 0, 0,            0, 0, 1, 2,  5,  0, 0, 0, 0, 5);
        repeat (3) @(posedge clock);
        if (q.size() != 0) begin
            nFail++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
